// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;
  // Tag index is sized for the largest supported requester count (8).
  localparam int TAG_IW   = 3;

  typedef struct packed {
    logic              wr;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_IW-1:0] index;
  } rd_tag_t;

  // Width of a requester index; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational round-robin search.
// Returns the first requester at or after ptr (wrapping) as one-hot and index.
module rr_priority_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [IW-1:0]   win_idx,
  output logic            win_valid
);

  logic [IW:0] cand_s;

  // Walk ptr, ptr+1, ... modulo NREQ and keep the first active request
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NREQ)) begin
        cand_s = cand_s - (IW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_valid && req[cand_s[IW-1:0]]) begin
        win_valid                    = 1'b1;
        win_idx                      = cand_s[IW-1:0];
        win_onehot[cand_s[IW-1:0]]   = 1'b1;
      end else begin
        win_valid = win_valid;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory command bus.
// Optional feature macro: MEM_ARB_LOCK_EN (adds req_lock and bounded grant locking).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
`ifdef MEM_ARB_LOCK_EN
  parameter int LOCK_MAX = 4,
`endif
  parameter int RD_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic               mem_wr,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IW = idx_width(NREQ);

  logic [NREQ-1:0] pick_req_s;
  logic [NREQ-1:0] pick_onehot_s;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_valid_s;

  logic [NREQ-1:0] sel_onehot_s;
  logic [IW-1:0]   sel_idx_s;
  logic            sel_valid_s;
  logic            sel_wr_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_wdata_s;
  logic            hold_ptr_s;

  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   ptr_nxt_s;
  logic [IW:0]     ptr_inc_s;

  logic [NREQ-1:0] gnt_r;
  logic            mem_en_r;
  logic            mem_wr_r;
  logic [AW-1:0]   mem_addr_r;
  logic [DW-1:0]   mem_wdata_r;

  rd_tag_t         tag_pipe_r [RD_LAT];
  logic [NREQ-1:0] rvalid_nxt_s;
  logic [NREQ-1:0] rvalid_r;

  rr_priority_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (pick_req_s),
    .ptr        (ptr_r),
    .win_onehot (pick_onehot_s),
    .win_idx    (pick_idx_s),
    .win_valid  (pick_valid_s)
  );

`ifdef MEM_ARB_LOCK_EN
  logic [IW-1:0] owner_r;
  logic [2:0]    lock_cnt_r;   // grants in the current owner's run, first grant counts as 1
  logic          lock_hold_s;
  logic          lock_skip_s;

  // Decide whether last cycle's owner keeps the bus or has used up its run
  always_comb begin
    lock_hold_s = 1'b0;
    lock_skip_s = 1'b0;
    if ((|gnt_r) && req[owner_r] && req_lock[owner_r]) begin
      if (lock_cnt_r >= 3'(LOCK_MAX)) begin
        lock_skip_s = 1'b1;
      end else begin
        lock_hold_s = 1'b1;
      end
    end else begin
      lock_hold_s = 1'b0;
    end
  end

  // Remove an exhausted owner from the round-robin search for one arbitration
  always_comb begin
    pick_req_s = req;
    if (lock_skip_s) begin
      pick_req_s[owner_r] = 1'b0;
    end else begin
      pick_req_s = req;
    end
  end

  // A locked owner overrides the round-robin winner and freezes the pointer
  always_comb begin
    sel_valid_s  = pick_valid_s;
    sel_idx_s    = pick_idx_s;
    sel_onehot_s = pick_onehot_s;
    hold_ptr_s   = 1'b0;
    if (lock_hold_s) begin
      sel_valid_s  = 1'b1;
      sel_idx_s    = owner_r;
      sel_onehot_s = gnt_r;
      hold_ptr_s   = 1'b1;
    end else begin
      hold_ptr_s   = 1'b0;
    end
  end

  // Track the owner and the length of its consecutive-grant run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r    <= '0;
      lock_cnt_r <= 3'd0;
    end else if (!sel_valid_s) begin
      lock_cnt_r <= 3'd0;
    end else if (lock_hold_s) begin
      lock_cnt_r <= lock_cnt_r + 3'd1;
    end else begin
      owner_r    <= sel_idx_s;
      lock_cnt_r <= 3'd1;
    end
  end
`else
  assign pick_req_s = req;

  // Pure round-robin: the picker's winner is the grant
  always_comb begin
    sel_valid_s  = pick_valid_s;
    sel_idx_s    = pick_idx_s;
    sel_onehot_s = pick_onehot_s;
    hold_ptr_s   = 1'b0;
  end
`endif

  // Gather the winner's command fields and the post-grant pointer
  always_comb begin
    sel_wr_s    = req_wr[sel_idx_s];
    sel_addr_s  = req_addr[sel_idx_s*AW +: AW];
    sel_wdata_s = req_wdata[sel_idx_s*DW +: DW];
    ptr_inc_s   = {1'b0, sel_idx_s} + (IW+1)'(1);
    if (hold_ptr_s) begin
      ptr_nxt_s = ptr_r;
    end else if (ptr_inc_s == (IW+1)'(NREQ)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = ptr_inc_s[IW-1:0];
    end
  end

  // Register the memory command bus and grant; idle cycles drive zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r       <= '0;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      ptr_r       <= '0;
    end else if (sel_valid_s) begin
      gnt_r       <= sel_onehot_s;
      mem_en_r    <= 1'b1;
      mem_wr_r    <= sel_wr_s;
      mem_addr_r  <= sel_addr_s;
      mem_wdata_r <= sel_wdata_s;
      ptr_r       <= ptr_nxt_s;
    end else begin
      gnt_r       <= '0;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end
  end

  // Read tags ride alongside the command and shift out RD_LAT cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_pipe_r[k] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= '{valid: sel_valid_s & ~sel_wr_s, index: TAG_IW'(sel_idx_s)};
      for (int k = 1; k < RD_LAT; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  // Decode the emerging tag into a one-hot return strobe
  always_comb begin
    rvalid_nxt_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      rvalid_nxt_s[k] = tag_pipe_r[RD_LAT-1].valid &&
                        (tag_pipe_r[RD_LAT-1].index == TAG_IW'(k));
    end
  end

  // Register the return strobe so it lines up with mem_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= '0;
    end else begin
      rvalid_r <= rvalid_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign mem_en    = mem_en_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rvalid    = rvalid_r;
  // Memory data is only meaningful in a return cycle; elsewhere rdata stays 0.
  assign rdata     = (|rvalid_r) ? mem_rdata : {DW{1'b0}};

endmodule
